// File: rtl/gate_response_checker.sv
// Exhaustive stimulus/response checker for a small combinational gate.
// Sweeps all input vectors, samples the gate output and scores it against EXPECT.
module gate_response_checker #(
  parameter int N_IN = 3,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 8'hFE,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST = N_IN'((1 << N_IN) - 1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N_IN-1:0] vec_n, ffi_n;
  logic [N_IN:0]   err_n;
  logic            busy_n, done_n, pass_n, ffv_n;
  logic            miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      vec_out          <= vec_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
      err_count        <= err_n;
      first_fail_valid <= ffv_n;
      first_fail_idx   <= ffi_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = DRIVE;
      DRIVE:   if (cnt == CMAX) state_n = SAMPLE;
      SAMPLE:  state_n = (vec_out == LAST) ? DONE : DRIVE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs; pass sees the final SAMPLE's miss.
  always_comb begin
    cnt_n  = cnt;
    vec_n  = vec_out;
    busy_n = busy;
    done_n = done;
    pass_n = pass;
    err_n  = err_count;
    ffv_n  = first_fail_valid;
    ffi_n  = first_fail_idx;
    miss   = dut_y != EXPECT[vec_out];
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_n  = '0;
          vec_n  = '0;
          busy_n = 1'b1;
          pass_n = 1'b0;
          err_n  = '0;
          ffv_n  = 1'b0;
          ffi_n  = '0;
        end
      end
      DRIVE: begin
        cnt_n = (cnt == CMAX) ? '0 : cnt + CW'(1);
      end
      SAMPLE: begin
        if (miss) begin
          err_n = err_count + (N_IN+1)'(1);
          if (!first_fail_valid) begin
            ffv_n = 1'b1;
            ffi_n = vec_out;
          end
        end
        if (vec_out == LAST) begin
          done_n = 1'b1;
          pass_n = (err_n == '0);
        end else begin
          vec_n = vec_out + N_IN'(1);
        end
      end
      DONE: begin
        busy_n = 1'b0;
        done_n = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
